// File: rtl/commit_trace_buffer_if.sv
// Commit-side (WB stage) and drain-side signals of the retire trace buffer.
// Drain handshake: a record transfers on each rising edge where rd_valid && rd_ready; rd_valid never depends on rd_ready.
interface commit_trace_buffer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int REG_W  = 4
);
    localparam int REC_W = 4 + REG_W + 2 * ADDR_W + 2 * DATA_W;

    logic [ADDR_W-1:0] wb_pc;
    logic              wb_regwrite;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_memread;
    logic              wb_memwrite;
    logic [ADDR_W-1:0] wb_memaddr;
    logic [DATA_W-1:0] wb_memwdata;
    logic [DATA_W-1:0] wb_memrdata;
    logic              wb_halt;

    logic              rd_valid;
    logic              rd_ready;
    logic [REC_W-1:0]  rd_data;

    modport master (
        output wb_pc, wb_regwrite, wb_rd, wb_wdata, wb_memread, wb_memwrite,
        output wb_memaddr, wb_memwdata, wb_memrdata, wb_halt, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  wb_pc, wb_regwrite, wb_rd, wb_wdata, wb_memread, wb_memwrite,
        input  wb_memaddr, wb_memwdata, wb_memrdata, wb_halt, rd_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Retire-event monitor: packs each WB commit into a record, queues it in a circular
// buffer drained over valid/ready, and tracks retire/cycle counters, halt and watchdog.
module commit_trace_buffer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 100000,
    parameter int OVERWRITE  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    commit_trace_buffer_if.slave     bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         retire_count,
    output logic                     halted,
    output logic                     overflow,
    output logic                     timeout,
    output logic                     proto_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = 4 + REG_W + 2 * ADDR_W + 2 * DATA_W;

    logic [REC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic              capture;
    logic              ev;
    logic              pop;
    logic              full;
    logic              evict;
    logic              drop;
    logic              do_write;
    logic              lvl_inc;
    logic              lvl_dec;
    logic              wdog_hit;
    logic [CNT_W-1:0]  cycle_next;
    logic [ADDR_W-1:0] rec_memaddr;
    logic [DATA_W-1:0] rec_regdata;
    logic [DATA_W-1:0] rec_memdata;
    logic [REC_W-1:0]  rec;

    always_comb begin
        capture = ~halted & ~timeout;
        ev      = capture & (bus.wb_regwrite | bus.wb_memread | bus.wb_memwrite | bus.wb_halt);

        rec_memaddr = (bus.wb_memread | bus.wb_memwrite) ? bus.wb_memaddr : '0;
        rec_regdata = bus.wb_regwrite ? bus.wb_wdata : '0;
        // A store takes precedence for memdata when both strobes are (illegally) set.
        if (bus.wb_memwrite) begin
            rec_memdata = bus.wb_memwdata;
        end else if (bus.wb_memread) begin
            rec_memdata = bus.wb_memrdata;
        end else begin
            rec_memdata = '0;
        end
        rec = {bus.wb_halt, bus.wb_memwrite, bus.wb_memread, bus.wb_regwrite,
               bus.wb_rd, bus.wb_pc, rec_memaddr, rec_regdata, rec_memdata};

        pop      = bus.rd_valid & bus.rd_ready;
        full     = (level == LVL_W'(DEPTH));
        evict    = ev & full & ~pop & (OVERWRITE != 0);
        drop     = ev & full & ~pop & (OVERWRITE == 0);
        do_write = ev & ~drop;
        // Eviction keeps the buffer full: the write replaces the popped-out oldest entry.
        lvl_inc  = do_write & ~pop & ~evict;
        lvl_dec  = pop & ~do_write;

        cycle_next = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
        wdog_hit   = capture & ~(ev & bus.wb_halt) & (cycle_next == CNT_W'(WDOG_LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            level        <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            halted       <= 1'b0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            proto_err    <= 1'b0;
        end else if (clr) begin
            head         <= '0;
            tail         <= '0;
            level        <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            halted       <= 1'b0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            if (do_write) tail <= tail + 1'b1;
            if (pop | evict) head <= head + 1'b1;
            if (lvl_inc) begin
                level <= level + 1'b1;
            end else if (lvl_dec) begin
                level <= level - 1'b1;
            end
            if (capture) cycle_count <= cycle_next;
            if (ev) retire_count <= retire_count + 1'b1;
            if (ev & bus.wb_halt) halted <= 1'b1;
            if (drop | evict) overflow <= 1'b1;
            if (wdog_hit) timeout <= 1'b1;
            if (capture & bus.wb_memread & bus.wb_memwrite) proto_err <= 1'b1;
        end
    end

    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_write && !clr) mem[tail] <= rec;
    end

    assign bus.rd_valid = (level != '0);
    assign bus.rd_data  = bus.rd_valid ? mem[head] : '0;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: three instances (drop policy, evict policy, short watchdog)
// share one stimulus stream; a queue model scores every drained record.
module tb_commit_trace_buffer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int REG_W  = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 32;
  localparam int LVL_W  = 3;
  localparam int REC_W  = 4 + REG_W + 2 * ADDR_W + 2 * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [ADDR_W-1:0] wb_pc = '0;
  logic              wb_regwrite = 1'b0;
  logic [REG_W-1:0]  wb_rd = '0;
  logic [DATA_W-1:0] wb_wdata = '0;
  logic              wb_memread = 1'b0;
  logic              wb_memwrite = 1'b0;
  logic [ADDR_W-1:0] wb_memaddr = '0;
  logic [DATA_W-1:0] wb_memwdata = '0;
  logic [DATA_W-1:0] wb_memrdata = '0;
  logic              wb_halt = 1'b0;
  logic              rd_ready = 1'b0;

  // index 0: OVERWRITE=0, 1: OVERWRITE=1, 2: WDOG_LIMIT=10
  logic              rd_valid [3];
  logic [REC_W-1:0]  rd_data [3];
  logic [LVL_W-1:0]  level [3];
  logic [CNT_W-1:0]  cycle_count [3];
  logic [CNT_W-1:0]  retire_count [3];
  logic              halted [3];
  logic              overflow [3];
  logic              timeout [3];
  logic              proto_err [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    commit_trace_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();
    assign bus.wb_pc       = wb_pc;
    assign bus.wb_regwrite = wb_regwrite;
    assign bus.wb_rd       = wb_rd;
    assign bus.wb_wdata    = wb_wdata;
    assign bus.wb_memread  = wb_memread;
    assign bus.wb_memwrite = wb_memwrite;
    assign bus.wb_memaddr  = wb_memaddr;
    assign bus.wb_memwdata = wb_memwdata;
    assign bus.wb_memrdata = wb_memrdata;
    assign bus.wb_halt     = wb_halt;
    assign bus.rd_ready    = rd_ready;
    assign rd_valid[g]     = bus.rd_valid;
    assign rd_data[g]      = bus.rd_data;

    commit_trace_buffer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W),
      .WDOG_LIMIT((g == 2) ? 10 : 1000), .OVERWRITE((g == 1) ? 1 : 0)
    ) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus),
      .level(level[g]), .cycle_count(cycle_count[g]), .retire_count(retire_count[g]),
      .halted(halted[g]), .overflow(overflow[g]), .timeout(timeout[g]), .proto_err(proto_err[g])
    );
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] exp_q_b[$];
  int m_cycle = 0;
  int m_retire = 0;
  bit m_halted = 1'b0;
  bit m_ovf_a = 1'b0;
  bit m_ovf_b = 1'b0;
  bit m_proto = 1'b0;

  function automatic logic [REC_W-1:0] build_rec();
    logic [ADDR_W-1:0] ma;
    logic [DATA_W-1:0] rv;
    logic [DATA_W-1:0] md;
    ma = (wb_memread || wb_memwrite) ? wb_memaddr : '0;
    rv = wb_regwrite ? wb_wdata : '0;
    md = wb_memwrite ? wb_memwdata : (wb_memread ? wb_memrdata : '0);
    return {wb_halt, wb_memwrite, wb_memread, wb_regwrite, wb_rd, wb_pc, ma, rv, md};
  endfunction

  always @(posedge clk) begin : scoreboard
    logic [REC_W-1:0] rec;
    logic [REC_W-1:0] exp;
    if (!rst_n || clr) begin
      exp_q.delete();
      exp_q_b.delete();
      m_cycle = 0;
      m_retire = 0;
      m_halted = 1'b0;
      m_ovf_a = 1'b0;
      m_ovf_b = 1'b0;
      m_proto = 1'b0;
    end else begin
      if (rd_ready && exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check_eq("rec_a", rd_data[0], exp);
      end
      if (rd_ready && exp_q_b.size() != 0) begin
        exp = exp_q_b.pop_front();
        check_eq("rec_b", rd_data[1], exp);
      end
      if (!m_halted) begin
        m_cycle++;
        if (wb_regwrite || wb_memread || wb_memwrite || wb_halt) begin
          rec = build_rec();
          m_retire++;
          if (wb_memread && wb_memwrite) m_proto = 1'b1;
          if (exp_q.size() < DEPTH) exp_q.push_back(rec);
          else m_ovf_a = 1'b1;
          if (exp_q_b.size() == DEPTH) begin
            void'(exp_q_b.pop_front());
            m_ovf_b = 1'b1;
          end
          exp_q_b.push_back(rec);
          if (wb_halt) m_halted = 1'b1;
        end
      end
    end
  end

  // Per-cycle status comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check_eq("level_a", level[0], exp_q.size());
      check_eq("level_b", level[1], exp_q_b.size());
      check_eq("valid_a", rd_valid[0], exp_q.size() != 0);
      check_eq("cycle_a", cycle_count[0], m_cycle);
      check_eq("retire_b", retire_count[1], m_retire);
      check_eq("halted_a", halted[0], m_halted);
      check_eq("ovf_a", overflow[0], m_ovf_a);
      check_eq("ovf_b", overflow[1], m_ovf_b);
      check_eq("proto_a", proto_err[0], m_proto);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    wb_pc = '0; wb_regwrite = 1'b0; wb_rd = '0; wb_wdata = '0;
    wb_memread = 1'b0; wb_memwrite = 1'b0; wb_memaddr = '0;
    wb_memwdata = '0; wb_memrdata = '0; wb_halt = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_retire(input logic rw, input logic mr, input logic mw, input logic hlt,
                              input logic [REG_W-1:0] rd, input logic [ADDR_W-1:0] pc,
                              input logic [DATA_W-1:0] wdata, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] mwdata, input logic [DATA_W-1:0] mrdata);
    wb_regwrite = rw; wb_memread = mr; wb_memwrite = mw; wb_halt = hlt;
    wb_rd = rd; wb_pc = pc; wb_wdata = wdata; wb_memaddr = addr;
    wb_memwdata = mwdata; wb_memrdata = mrdata;
    @(negedge clk);
    set_idle();
  endtask

  task automatic drive_store(input int i);
    drive_retire(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0010 + 16'(2 * i), 16'h0,
                 16'h0100 + 16'(i), 16'h1000 + 16'(i), 16'h0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    set_idle();
    @(negedge clk);
    #1;
    check_eq("rst_level", level[0], 0);
    check_eq("rst_valid", rd_valid[0], 0);
    check_eq("rst_data", rd_data[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(3);
    check_eq("idle_cycle", cycle_count[0], 3);
    check_eq("idle_retire", retire_count[0], 0);
    check_eq("idle_level", level[0], 0);

    // ADD R3 then LW R5
    do_clr();
    drive_retire(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0004, 16'h0012, 16'h0, 16'h0, 16'h0);
    drive_retire(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0006, 16'hBEEF, 16'h0040, 16'h0, 16'hBEEF);
    check_eq("two_retire", retire_count[0], 2);
    check_eq("two_level", level[0], 2);
    check_eq("add_rec", rd_data[0], {4'b0001, 4'd3, 16'h0004, 16'h0000, 16'h0012, 16'h0000});
    rd_ready = 1'b1;
    @(negedge clk);
    check_eq("lw_rec", rd_data[0], {4'b0011, 4'd5, 16'h0006, 16'h0040, 16'hBEEF, 16'hBEEF});
    @(negedge clk);
    rd_ready = 1'b0;

    // six stores into a 4-deep buffer: drop newest vs evict oldest
    do_clr();
    for (int i = 1; i <= 6; i++) drive_store(i);
    check_eq("full_level_a", level[0], 4);
    check_eq("full_ovf_a", overflow[0], 1);
    check_eq("full_level_b", level[1], 4);
    check_eq("full_ovf_b", overflow[1], 1);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drop_order", rd_data[0][15:0], 16'h1001 + 16'(i));
      check_eq("evict_order", rd_data[1][15:0], 16'h1003 + 16'(i));
      @(negedge clk);
    end
    rd_ready = 1'b0;

    // full buffer, push and pop in the same cycle
    do_clr();
    for (int i = 1; i <= 4; i++) drive_store(i);
    rd_ready = 1'b1;
    drive_store(5);
    rd_ready = 1'b0;
    check_eq("pp_level", level[0], 4);
    check_eq("pp_ovf_a", overflow[0], 0);
    check_eq("pp_ovf_b", overflow[1], 0);
    check_eq("pp_head", rd_data[0][15:0], 16'h1002);
    rd_ready = 1'b1;
    idle(4);
    rd_ready = 1'b0;

    // halt, then retire attempts that must be ignored
    do_clr();
    drive_retire(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0020, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++)
      drive_retire(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 16'h0022, 16'h00AA, 16'h0, 16'h0, 16'h0);
    check_eq("halt_flag", halted[0], 1);
    check_eq("halt_cycle", cycle_count[0], 1);
    check_eq("halt_retire", retire_count[0], 1);
    check_eq("halt_rec", rd_data[0], {4'b1000, 4'd0, 16'h0020, 48'h0});
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    check_eq("halt_drain", level[0], 0);
    do_clr();
    check_eq("clr_halted", halted[0], 0);
    check_eq("clr_cycle", cycle_count[0], 0);
    check_eq("clr_retire", retire_count[0], 0);
    check_eq("clr_valid", rd_valid[0], 0);

    // watchdog on the short-limit instance, plus a load/store collision
    do_clr();
    idle(9);
    check_eq("wdog_pre_cycle", cycle_count[2], 9);
    check_eq("wdog_pre_to", timeout[2], 0);
    idle(1);
    check_eq("wdog_cycle", cycle_count[2], 10);
    check_eq("wdog_to", timeout[2], 1);
    drive_retire(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 16'h0030, 16'h1111, 16'h0050, 16'h2222, 16'h3333);
    idle(2);
    check_eq("wdog_frozen", cycle_count[2], 10);
    check_eq("wdog_retire", retire_count[2], 0);
    check_eq("wdog_level", level[2], 0);
    check_eq("wdog_proto", proto_err[2], 0);
    check_eq("proto_set", proto_err[0], 1);
    check_eq("proto_flags", rd_data[0][70:69], 2'b11);
    check_eq("proto_mdata", rd_data[0][15:0], 16'h2222);
    rd_ready = 1'b1;
    idle(2);
    rd_ready = 1'b0;

    // reset in the middle of a drain
    do_clr();
    for (int i = 1; i <= 3; i++) drive_store(i);
    rd_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_level", level[0], 0);
    check_eq("mid_rst_valid", rd_valid[0], 0);
    check_eq("mid_rst_data", rd_data[0], 0);
    rd_ready = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      rd_ready = 1'($urandom_range(0, 1));
      drive_retire(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), 1'b0, 4'($urandom_range(0, 15)),
                   16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                   16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                   16'($urandom_range(0, 65535)));
    end
    rd_ready = 1'b1;
    idle(6);
    check_eq("final_empty_a", exp_q.size(), 0);
    check_eq("final_empty_b", exp_q_b.size(), 0);
    rd_ready = 1'b0;
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Synthesizable retire-event monitor for the 16-bit pipelined cpu. It watches the WB-stage commit signals and packs each retiring instruction into one record: PC, register write, load and store data. Records go into a parametrised circular buffer that is drained over a valid/ready port. It also keeps retire and cycle counters, a halt freeze and a cycle-limit watchdog, so the same checks run in hardware/FPGA debug as in simulation.

Parameters:
DATA_W, 16, register and memory data width
ADDR_W, 16, PC and memory address width
REG_W, 4, register index width
DEPTH, 16, buffer entries; power of 2, >= 2
CNT_W, 32, width of the cycle and retire counters
WDOG_LIMIT, 100000, cycle count at which the watchdog fires
OVERWRITE, 0, full policy: 0 = drop the new record, 1 = evict the oldest record

Ports:
clk in 1 system clock, all state on the rising edge
rst_n in 1 asynchronous active-low reset
clr in 1 synchronous clear of buffer, counters and sticky flags
wb_pc in ADDR_W PC of the instruction in WB
wb_regwrite in 1 WB register write enable
wb_rd in REG_W WB destination register
wb_wdata in DATA_W WB register write data
wb_memread in 1 WB instruction performed a load
wb_memwrite in 1 WB instruction performed a store
wb_memaddr in ADDR_W WB memory address
wb_memwdata in DATA_W store data
wb_memrdata in DATA_W load data
wb_halt in 1 HLT in WB
rd_valid out 1 head record available
rd_ready in 1 consumer accepts the head record
rd_data out 4+REG_W+2*ADDR_W+2*DATA_W head record, packed MSB to LSB as: {hlt,mw,mr,rw, rd, pc, memaddr, regdata, memdata}
level out log2(DEPTH)+1 number of occupied entries
cycle_count out CNT_W cycles counted since capture was enabled
retire_count out CNT_W records accepted for push
halted out 1 sticky: halt has retired
overflow out 1 sticky: a record was lost
timeout out 1 sticky: watchdog fired
proto_err out 1 sticky: memread and memwrite asserted together

Behaviour:
- Reset (async, rst_n=0): all pointers, level, counters and sticky flags = 0; rd_valid = 0; rd_data = 0. Storage array contents are don't-care.
- clr=1: same effect as reset, applied on the clock edge. clr has priority over every other event in that cycle.
- Capture is enabled when rst_n=1, clr=0, halted=0 and timeout=0.
- While capture is enabled, cycle_count increments by 1 each cycle and saturates at all-ones.
- Retire event: ev = wb_regwrite | wb_memread | wb_memwrite | wb_halt, sampled only while capture is enabled.
- On each ev, one record is pushed:
  - rw/mr/mw/hlt flags copy the corresponding inputs.
  - rd = wb_rd.
  - pc = wb_pc.
  - memaddr = wb_memaddr if mr|mw, else 0.
  - regdata = wb_wdata if rw, else 0.
  - memdata = wb_memwdata if mw, wb_memrdata if mr, else 0.
- retire_count increments on every ev, whether or not the record is stored.
- memread & memwrite in the same cycle: proto_err is set, the record is still pushed, and mr=mw=1 in the record.
- wb_halt: the halt record is pushed, then halted is set at that edge. No further pushes and cycle_count is frozen. Draining continues. Only clr or reset leaves the halted state.
- Watchdog: when cycle_count reaches WDOG_LIMIT with halted=0, timeout is set and capture freezes (draining continues).
- Read side is show-ahead: rd_data = mem[head] combinationally and rd_valid = (level != 0). A pop happens when rd_valid & rd_ready.
- Push and pop in the same cycle, any level: both happen and level is unchanged. A pop on empty is ignored.
- Full (level == DEPTH), push without pop:
  - OVERWRITE=0: record discarded, overflow set, pointers unchanged.
  - OVERWRITE=1: record written at tail, head and tail both advance, level stays DEPTH, overflow set.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is the full-width occupancy.
- Reset asserted mid-drain discards all content immediately, with no partial pop.

Test Plan:
- Reset then 3 cycles idle: level=0, rd_valid=0, cycle_count=3, retire_count=0.
- ADD R3 retire (rw=1, rd=3, wdata=0x0012, pc=0x0004), then LW R5 (rw=1, mr=1, rd=5, addr=0x0040, rdata=0xBEEF) -> two records in order; second record has regdata=0xBEEF, memdata=0xBEEF, memaddr=0x0040; retire_count=2.
- DEPTH=4, OVERWRITE=0, 6 stores with rd_ready=0 -> level=4, overflow=1, drained records are stores 1-4. Repeat with OVERWRITE=1 -> drained records are stores 3-6.
- level=4 (full), push with rd_ready=1 in the same cycle -> level stays 4, overflow=0, head advances.
- Halt at pc=0x0020 followed by further wb_regwrite pulses -> halt record stored with hlt=1 and pc=0x0020; halted=1; cycle_count and retire_count frozen; clr restores all zero state.
- WDOG_LIMIT=10, no halt -> timeout=1 at cycle_count=10 and counters freeze. Also: memread=memwrite=1 together -> proto_err=1.
